// File: rtl/buzzer_sequencer.sv
// Note queue feeding a square-wave buzzer: each note is a half-period and a duration in ticks.
// Optional build macro BUZZER_SEQ_GAP_EN inserts GAP_TICKS silent ticks after every note.
module buzzer_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TICK_DIV   = 1000,
    parameter int GAP_TICKS  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        note_valid,
    output logic                        note_ready,
    input  logic [15:0]                 note_half_period,
    input  logic [15:0]                 note_duration,
    output logic                        buzz,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

`ifdef BUZZER_SEQ_GAP_EN
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
    // The gap reuses the tick and remaining-duration counters, so GAP_TICKS must fit 16 bits.
    localparam logic [15:0] GAP_LD = 16'(GAP_TICKS);
`else
    typedef enum logic [1:0] {IDLE, PLAY} state_t;
    logic unused_gap;
    assign unused_gap = (GAP_TICKS > 0);
`endif

    typedef struct packed {
        logic [15:0] half;
        logic [15:0] dur;
    } note_t;

    note_t          mem_q [FIFO_DEPTH];
    note_t          head;
    state_t         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [15:0]    half_per_q, half_per_d;
    logic [15:0]    half_cnt_q, half_cnt_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [15:0]    dur_rem_q, dur_rem_d;
    logic           buzz_q, buzz_d;
    logic           push, pop;

    assign head       = mem_q[rd_ptr_q];
    assign note_ready = en && (count_q < CW'(FIFO_DEPTH));
    assign push       = note_valid && note_ready;
    assign buzz       = buzz_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{half: note_half_period, dur: note_duration};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            half_per_q <= '0;
            half_cnt_q <= '0;
            tick_cnt_q <= '0;
            dur_rem_q  <= '0;
            buzz_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            half_per_q <= half_per_d;
            half_cnt_q <= half_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            dur_rem_q  <= dur_rem_d;
            buzz_q     <= buzz_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        half_per_d = half_per_q;
        half_cnt_d = half_cnt_q;
        tick_cnt_d = tick_cnt_q;
        dur_rem_d  = dur_rem_q;
        buzz_d     = buzz_q;
        pop        = 1'b0;
        if (!en) begin
            state_d    = IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            half_per_d = '0;
            half_cnt_d = '0;
            tick_cnt_d = '0;
            dur_rem_d  = '0;
            buzz_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        pop = 1'b1;
                        // Zero-duration notes are dropped here and cost one IDLE cycle.
                        if (head.dur != 16'd0) begin
                            state_d    = PLAY;
                            half_per_d = head.half;
                            half_cnt_d = '0;
                            tick_cnt_d = '0;
                            dur_rem_d  = head.dur;
                            buzz_d     = (head.half != 16'd0);
                        end
                    end
                end
                PLAY: begin
                    if (half_per_q != 16'd0) begin
                        if (half_cnt_q == half_per_q - 16'd1) begin
                            half_cnt_d = '0;
                            buzz_d     = ~buzz_q;
                        end else begin
                            half_cnt_d = half_cnt_q + 16'd1;
                        end
                    end
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        dur_rem_d  = dur_rem_q - 16'd1;
                        if (dur_rem_q == 16'd1) begin
                            buzz_d     = 1'b0;
                            half_cnt_d = '0;
`ifdef BUZZER_SEQ_GAP_EN
                            if (GAP_LD == 16'd0) begin
                                state_d = IDLE;
                            end else begin
                                state_d   = GAP;
                                dur_rem_d = GAP_LD;
                            end
`else
                            state_d = IDLE;
`endif
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
`ifdef BUZZER_SEQ_GAP_EN
                GAP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        dur_rem_d  = dur_rem_q - 16'd1;
                        if (dur_rem_q == 16'd1) state_d = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed plus random stimulus for buzzer_sequencer against a note-level timeline model.
module tb_buzzer_sequencer;
    localparam int TD = 4;
    localparam int FD = 4;
    localparam int GT = 1;
`ifdef BUZZER_SEQ_GAP_EN
    localparam int GAPC = GT * TD;
`else
    localparam int GAPC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, note_valid, note_ready, buzz, busy;
    logic [15:0] note_half_period, note_duration;
    logic [2:0]  fifo_count;
    int          n_chk = 0;
    int          n_err = 0;

    typedef struct {
        int h;
        int d;
    } mnote_t;
    mnote_t mq[$];
    int m_mode;   // 0 idle, 1 playing, 2 silent gap
    int m_k, m_len, m_h, m_gk;

    always #5 clk = ~clk;

    buzzer_sequencer #(.FIFO_DEPTH(FD), .TICK_DIV(TD), .GAP_TICKS(GT)) dut (
        .clk(clk), .rst(rst), .en(en), .note_valid(note_valid), .note_ready(note_ready),
        .note_half_period(note_half_period), .note_duration(note_duration),
        .buzz(buzz), .busy(busy), .fifo_count(fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = 0; m_k = 0; m_len = 0; m_h = 0; m_gk = 0;
    endtask

    // One clock edge of the note timeline: a note lasts dur*TD cycles, the wave flips every h cycles.
    task automatic model_edge(input bit e, input bit push, input int h, input int d);
        mnote_t n;
        if (!e) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: if (mq.size() > 0) begin
                n = mq.pop_front();
                if (n.d != 0) begin
                    m_mode = 1; m_k = 0; m_h = n.h; m_len = n.d * TD;
                end
            end
            1: begin
                m_k++;
                if (m_k == m_len) begin
                    if (GAPC > 0) begin m_mode = 2; m_gk = 0; end
                    else m_mode = 0;
                end
            end
            default: begin
                m_gk++;
                if (m_gk == GAPC) m_mode = 0;
            end
        endcase
        if (push) begin
            n.h = h; n.d = d;
            mq.push_back(n);
        end
    endtask

    function automatic int exp_buzz();
        return (m_mode == 1 && m_h != 0 && ((m_k / m_h) % 2 == 0)) ? 1 : 0;
    endfunction

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic step(input bit e, input bit v, input int h, input int d);
        bit rdy;
        en = e; note_valid = v;
        note_half_period = 16'(h); note_duration = 16'(d);
        #1;
        rdy = e && (mq.size() < FD);
        chk("note_ready", 32'(note_ready), 32'(rdy));
        @(posedge clk);
        model_edge(e, v && rdy, h, d);
        @(negedge clk);
        chk("buzz", 32'(buzz), 32'(exp_buzz()));
        chk("busy", 32'(busy), 32'((m_mode != 0 || mq.size() > 0) ? 1 : 0));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_buzz", 32'(buzz), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; note_valid = 1'b0;
        note_half_period = '0; note_duration = '0;
        model_reset();
        @(negedge clk);
        chk("reset_buzz", 32'(buzz), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_count", 32'(fifo_count), 32'd0);
        chk("reset_ready", 32'(note_ready), 32'd0);
        rst = 1'b0;

        // Single note into an empty queue, then drain.
        step(1, 1, 2, 3);
        repeat (22) step(1, 0, 0, 0);

        // Fill the queue while the first long note plays; keep offering until it drains.
        for (int i = 0; i < 5; i++) step(1, 1, 1, 10);
        chk("full_count", 32'(fifo_count), 32'd4);
        repeat (45) step(1, 1, 1, 10);

        // Disable mid-note with a loaded queue.
        step(0, 1, 1, 1);
        chk("flush_count", 32'(fifo_count), 32'd0);
        step(0, 1, 1, 1);

        // Rest note followed by fastest toggle.
        step(1, 1, 0, 2);
        step(1, 1, 1, 1);
        repeat (16) step(1, 0, 0, 0);

        // Discarded zero-length note followed by a short note.
        step(1, 1, 3, 0);
        step(1, 1, 3, 1);
        repeat (10) step(1, 0, 0, 0);

        // Asynchronous reset mid-note, then latency of the first note afterwards.
        step(1, 1, 2, 5);
        step(1, 1, 1, 2);
        repeat (5) step(1, 0, 0, 0);
        mid_reset();
        step(1, 1, 2, 1);
        repeat (8) step(1, 0, 0, 0);

        repeat (400) step($urandom_range(0, 19) != 0, $urandom_range(0, 2) == 0,
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        repeat (30) step(1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/buzzer_sequencer.md
BUZZER_SEQUENCER -- requirements
Module: buzzer_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, note queue depth (power of two, 2..16).
REQ-002 SHALL have parameter TICK_DIV, default 1000, clock cycles per duration tick (>=1).
REQ-003 SHALL have parameter GAP_TICKS, default 1, silent ticks between notes (used only with BUZZER_SEQ_GAP_EN).
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  sequencer enable (driven from buzzer ctrl_en); low = flush and silence.
REQ-007 SHALL have port note_valid  input  1  producer offers a note.
REQ-008 SHALL have port note_ready  output  1  queue accepts a note this cycle.
REQ-009 SHALL have port note_half_period  input  16  clock cycles per half wave; 0 = rest (silent note).
REQ-010 SHALL have port note_duration  input  16  note length in ticks; 0 = discard.
REQ-011 SHALL have port buzz  output  1  square-wave drive to buzzer.
REQ-012 SHALL have port busy  output  1  high when state != IDLE or queue non-empty.
REQ-013 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  queued notes.

Function
REQ-014 note_ready SHALL equal en && fifo_count < FIFO_DEPTH, combinationally; a pop in the same cycle SHALL NOT make a full queue ready.
REQ-015 A note SHALL be enqueued on a rising edge where note_valid && note_ready; simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 States SHALL be IDLE, PLAY, GAP; buzz SHALL be 0 in IDLE and GAP.
REQ-017 IDLE: if en and fifo_count > 0, head SHALL be popped; duration 0 -> discarded, stay IDLE; else load counters, go PLAY.
REQ-018 On entry to PLAY, buzz SHALL be 1 if half_period != 0, else 0; tick and half-wave counters SHALL start at 0.
REQ-019 PLAY: half-wave counter SHALL count 0..half_period-1 and toggle buzz on wrap; half_period 0 SHALL hold buzz at 0.
REQ-020 PLAY: tick counter SHALL count 0..TICK_DIV-1; on wrap the remaining duration SHALL decrement.
REQ-021 Decrement from 1 to 0 SHALL leave PLAY on that edge: buzz 0, next state GAP (macro defined) or IDLE; note SHALL occupy exactly duration*TICK_DIV cycles in PLAY.
REQ-022 Latency: a note pushed into an empty queue while IDLE at edge N SHALL be popped at edge N+1 with buzz high after edge N+1.
REQ-023 en low at any edge SHALL force IDLE, flush queue (fifo_count 0), clear counters, buzz 0; pushes that cycle SHALL be rejected.
REQ-024 Counters SHALL be wide enough for 16-bit values and TICK_DIV without overflow; no arithmetic SHALL wrap silently.

Reset
REQ-025 rst high SHALL asynchronously set state IDLE, pointers and fifo_count 0, all counters 0, buzz 0, busy 0.
REQ-026 rst mid-note SHALL discard the note and queue; first post-reset note SHALL behave per REQ-022.

Configuration
REQ-027 Macro BUZZER_SEQ_GAP_EN defined: GAP state SHALL hold buzz 0 for GAP_TICKS*TICK_DIV cycles then go IDLE; GAP_TICKS 0 SHALL skip GAP.
REQ-028 BUZZER_SEQ_GAP_EN undefined: GAP state and its counter SHALL not exist; PLAY SHALL go directly to IDLE, allowing back-to-back notes with one IDLE cycle between.

Verification (TICK_DIV=4, FIFO_DEPTH=4, GAP_TICKS=1)
REQ-029 Push {half=2, dur=3} into empty queue, en=1 -> buzz 1,1,0,0,1,1,... for 12 cycles starting after the pop edge, then 0; busy falls after PLAY (plus 4 gap cycles with macro).
REQ-030 Push 5 notes back-to-back while IDLE, dur=10 -> first pops immediately, pushes 2-5 accepted, note_ready low once fifo_count=4; pop and push same cycle keeps count at 4.
REQ-031 Push {half=0, dur=2} then {half=1, dur=1} -> buzz 0 for 8 cycles, then toggles every cycle for 4 cycles.
REQ-032 Push {dur=0} then {half=3, dur=1} -> first discarded in one IDLE cycle, second plays 4 cycles, buzz 1,1,1,0.
REQ-033 Deassert en mid-note with 2 queued -> next edge buzz 0, fifo_count 0, busy 0, note_ready 0.
REQ-034 Assert rst mid-note -> buzz 0, fifo_count 0 immediately without a clock edge; post-reset note plays per REQ-022.
